// File: rtl/contador_modular_param.sv
// Parametrised up/down modulo counter with programmable bounds, load and four
// end-of-range modes (wrap, saturate, ping-pong, one-shot).
module contador_modular_param #(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             resetar,
  input  logic             en,
  input  logic             decrescente,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] min_value,
  input  logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             dir,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [1:0]       MODE_WRAP = 2'b00;
  localparam logic [1:0]       MODE_SAT  = 2'b01;
  localparam logic [1:0]       MODE_PP   = 2'b10;
  localparam logic [1:0]       MODE_ONE  = 2'b11;
  localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] count_r, count_nxt_s;
  logic             tc_r, tc_nxt_s;
  logic             dir_r;
  logic             done_r, done_nxt_s;
  logic             pp_dir_r, pp_dir_nxt_s;
  logic             d_s;
  logic [WIDTH-1:0] start_s, term_s;
  logic             oor_s;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] hi);
    logic [WIDTH-1:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign cfg_err = (min_value > max_value);
  assign d_s     = (mode == MODE_PP) ? pp_dir_r : decrescente;
  assign start_s = d_s ? max_value : min_value;
  assign term_s  = d_s ? min_value : max_value;
  assign oor_s   = (count_r < min_value) || (count_r > max_value);

  // Next-state selection in precedence order: load, config error, range, step.
  always_comb begin
    count_nxt_s  = count_r;
    tc_nxt_s     = 1'b0;
    done_nxt_s   = done_r;
    pp_dir_nxt_s = (mode == MODE_PP) ? pp_dir_r : decrescente;
    if (load) begin
      count_nxt_s = clamp(load_value, min_value, max_value);
      done_nxt_s  = 1'b0;
    end else if (cfg_err) begin
      count_nxt_s = count_r;
    end else if (!en) begin
      count_nxt_s = count_r;
    end else if (oor_s) begin
      count_nxt_s = start_s;
    end else if (count_r != term_s) begin
      count_nxt_s = d_s ? (count_r - ONE) : (count_r + ONE);
    end else begin
      case (mode)
        MODE_WRAP: begin
          count_nxt_s = start_s;
          tc_nxt_s    = 1'b1;
        end
        MODE_SAT: begin
          count_nxt_s = count_r;
        end
        MODE_PP: begin
          // Degenerate one-value range keeps count but still bounces direction.
          if (min_value == max_value) begin
            count_nxt_s = count_r;
          end else begin
            count_nxt_s = d_s ? (min_value + ONE) : (max_value - ONE);
          end
          pp_dir_nxt_s = ~pp_dir_r;
          tc_nxt_s     = 1'b1;
        end
        MODE_ONE: begin
          if (!done_r) begin
            done_nxt_s = 1'b1;
            tc_nxt_s   = 1'b1;
          end else begin
            done_nxt_s = done_r;
          end
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge resetar) begin
    if (resetar) begin
      count_r  <= RST_VAL;
      tc_r     <= 1'b0;
      dir_r    <= 1'b0;
      done_r   <= 1'b0;
      pp_dir_r <= 1'b0;
    end else begin
      count_r  <= count_nxt_s;
      tc_r     <= tc_nxt_s;
      dir_r    <= d_s;
      done_r   <= done_nxt_s;
      pp_dir_r <= pp_dir_nxt_s;
    end
  end

  assign count = count_r;
  assign tc    = tc_r;
  assign dir   = dir_r;
  assign done  = done_r;

endmodule

// File: tb/tb_contador_modular_param.sv
// Scoreboard bench for contador_modular_param (WIDTH=4, RESET_VALUE=0).
module tb_contador_modular_param;

  logic       clk;
  logic       resetar;
  logic       en;
  logic       decrescente;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] min_value;
  logic [3:0] max_value;
  logic [3:0] count;
  logic       tc;
  logic       dir;
  logic       done;
  logic       cfg_err;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       tc;
    logic       dir;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  contador_modular_param #(.WIDTH(4), .RESET_VALUE(0)) dut (
    .clk        (clk),
    .resetar    (resetar),
    .en         (en),
    .decrescente(decrescente),
    .mode       (mode),
    .load       (load),
    .load_value (load_value),
    .min_value  (min_value),
    .max_value  (max_value),
    .count      (count),
    .tc         (tc),
    .dir        (dir),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, then pop and compare after it.
  task automatic cycle(input string tag, input int c, input int t, input int d, input int dn);
    exp_t e;
    exp_t g;
    e.tag = tag; e.cnt = 4'(c); e.tc = t[0]; e.dir = d[0]; e.done = dn[0];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 1, 0);
    end else begin
      g = sb_q.pop_front();
      check_eq({g.tag, "_count"}, int'(count), int'(g.cnt));
      check_eq({g.tag, "_tc"},    int'(tc),    int'(g.tc));
      check_eq({g.tag, "_dir"},   int'(dir),   int'(g.dir));
      check_eq({g.tag, "_done"},  int'(done),  int'(g.done));
    end
  endtask

  initial begin
    resetar = 1'b1; en = 1'b0; decrescente = 1'b0; mode = 2'b00; load = 1'b0;
    load_value = 4'd0; min_value = 4'd0; max_value = 4'd9;
    #12;
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_tc", int'(tc), 0);
    check_eq("rst_dir", int'(dir), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_cfg_err", int'(cfg_err), 0);
    resetar = 1'b0;

    // wrap up 0..9
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle("wrap_up", i % 10, (i % 10 == 0) ? 1 : 0, 0, 0);
    end

    // wrap down 3..12 with load
    decrescente = 1'b1; min_value = 4'd3; max_value = 4'd12;
    load = 1'b1; load_value = 4'd5;
    cycle("wrap_dn_load", 5, 0, 1, 0);
    load = 1'b0;
    cycle("wrap_dn", 4, 0, 1, 0);
    cycle("wrap_dn", 3, 0, 1, 0);
    cycle("wrap_dn_tc", 12, 1, 1, 0);
    cycle("wrap_dn", 11, 0, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle("hold_en0", 11, 0, 1, 0);

    // ping-pong 2..5
    decrescente = 1'b0; min_value = 4'd2; max_value = 4'd5;
    load = 1'b1; load_value = 4'd2;
    cycle("pp_load", 2, 0, 0, 0);
    load = 1'b0; mode = 2'b10; en = 1'b1;
    cycle("pp", 3, 0, 0, 0);
    cycle("pp", 4, 0, 0, 0);
    cycle("pp", 5, 0, 0, 0);
    cycle("pp_bounce_hi", 4, 1, 0, 0);
    cycle("pp", 3, 0, 1, 0);
    cycle("pp", 2, 0, 1, 0);
    cycle("pp_bounce_lo", 3, 1, 1, 0);
    cycle("pp", 4, 0, 0, 0);

    // one-shot 0..3
    mode = 2'b11; min_value = 4'd0; max_value = 4'd3; en = 1'b0;
    load = 1'b1; load_value = 4'd0;
    cycle("os_load", 0, 0, 0, 0);
    load = 1'b0; en = 1'b1;
    cycle("os", 1, 0, 0, 0);
    cycle("os", 2, 0, 0, 0);
    cycle("os", 3, 0, 0, 0);
    cycle("os_done", 3, 1, 0, 1);
    cycle("os_after", 3, 0, 0, 1);
    cycle("os_after", 3, 0, 0, 1);
    load = 1'b1; load_value = 4'd1;
    cycle("os_reload", 1, 0, 0, 0);
    load = 1'b0;

    // load clamp beats en
    mode = 2'b00; min_value = 4'd0; max_value = 4'd9;
    load = 1'b1; load_value = 4'd15; en = 1'b1;
    cycle("load_clamp", 9, 0, 0, 0);
    load = 1'b0;

    // inverted bounds freeze
    min_value = 4'd8; max_value = 4'd4;
    #1;
    check_eq("cfg_err_set", int'(cfg_err), 1);
    cycle("cfg_freeze", 9, 0, 0, 0);
    cycle("cfg_freeze", 9, 0, 0, 0);

    // bounds shrink below count
    min_value = 4'd2; max_value = 4'd15;
    #1;
    check_eq("cfg_err_clr", int'(cfg_err), 0);
    load = 1'b1; load_value = 4'd12;
    cycle("oor_load", 12, 0, 0, 0);
    load = 1'b0; max_value = 4'd9;
    cycle("oor_to_min", 2, 0, 0, 0);

    // saturate
    mode = 2'b01; max_value = 4'd5;
    load = 1'b1; load_value = 4'd4;
    cycle("sat_load", 4, 0, 0, 0);
    load = 1'b0;
    cycle("sat", 5, 0, 0, 0);
    cycle("sat_hold", 5, 0, 0, 0);

    // wrap with min==max
    mode = 2'b00; min_value = 4'd7; max_value = 4'd7;
    cycle("eq_oor", 7, 0, 0, 0);
    cycle("eq_tc", 7, 1, 0, 0);
    cycle("eq_tc", 7, 1, 0, 0);

    // async reset mid-count while ping-ponging down
    min_value = 4'd0; max_value = 4'd9; decrescente = 1'b1; en = 1'b0;
    load = 1'b1; load_value = 4'd8;
    cycle("rst_prep", 8, 0, 1, 0);
    load = 1'b0; mode = 2'b10; en = 1'b1;
    cycle("rst_prep_pp", 7, 0, 1, 0);
    #2;
    resetar = 1'b1;
    #1;
    check_eq("async_rst_count", int'(count), 0);
    check_eq("async_rst_dir", int'(dir), 0);
    check_eq("async_rst_tc", int'(tc), 0);
    check_eq("async_rst_done", int'(done), 0);
    #1;
    resetar = 1'b0;
    cycle("post_rst_up", 1, 0, 0, 0);
    cycle("post_rst_up", 2, 0, 0, 0);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/contador_modular_param.md
Name: contador_modular_param

Overview:
- Parametrised up/down modulo counter; next generation of the team's 4-bit bounded counter.
- Adds:
  - configurable width;
  - programmable lower and upper bounds;
  - count enable;
  - synchronous parallel load;
  - four end-of-range modes: wrap, saturate, ping-pong, one-shot.
- Drives display/timing sequencers; `tc` can feed `en` of a downstream instance for cascading.

Parameters:
- WIDTH, 4, counter/bound width in bits (≥2).
- RESET_VALUE, 0, value of `count` after reset (must fit in WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- resetar  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; no step when 0.
- decrescente  in  1  direction request: 0 up, 1 down.
- mode  in  2  00 wrap, 01 saturate, 10 ping-pong, 11 one-shot.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value loaded when load=1.
- min_value  in  WIDTH  lower bound (inclusive).
- max_value  in  WIDTH  upper bound (inclusive).
- count  out  WIDTH  registered count.
- tc  out  1  registered terminal pulse (wrap/bounce/one-shot end).
- dir  out  1  registered effective direction (0 up, 1 down).
- done  out  1  one-shot complete, sticky.
- cfg_err  out  1  combinational, 1 when min_value > max_value.

Behaviour:
- Reset (async, resetar=1): count=RESET_VALUE, tc=0, dir=0, done=0, ping-pong direction register=0.
- Precedence each rising edge: resetar > load > cfg_err > out-of-range > en step > hold.
- Effective direction d = (mode==10) ? pingpong_dir_reg : decrescente. The `dir` output registers d every cycle.
- Outside ping-pong mode, pingpong_dir_reg <= decrescente every cycle, so entering ping-pong continues in the last requested direction.
- "Start bound" = min_value if d=0, max_value if d=1.
- "Terminal bound" = max_value if d=0, min_value if d=1.
- load=1: count <= load_value clamped to [min_value, max_value]; done <= 0; tc <= 0. Load wins over en in the same cycle.
- cfg_err=1: count holds, tc=0, done holds.
- Out-of-range (count < min or count > max) with en=1: count <= start bound, tc=0.
- tc is 0 in every cycle not listed below; its latency matches count (same edge).
- Normal step, en=1, count ≠ terminal bound: count <= count+1 (d=0) or count−1 (d=1); tc <= 0.
- At terminal bound with en=1, by mode:
  - wrap (00): count <= start bound; tc <= 1 on the same edge.
  - saturate (01): count holds; tc <= 0.
  - ping-pong (10):
    - count <= bound ∓ 1 (i.e., max−1 going up, min+1 going down);
    - pingpong_dir_reg toggles; tc <= 1;
    - if min==max, count holds, direction still toggles, tc <= 1.
  - one-shot (11):
    - if done=0: count holds, done <= 1, tc <= 1 (single pulse);
    - if done=1: en is ignored, tc=0.
- Arithmetic: modulo-2^WIDTH intermediate is never exposed; bounds guarantee no 0−1 or all-ones+1 reaches count.
- Mode change mid-count: takes effect on the next edge; no state is flushed. done clears only on load or reset.
- min==max in wrap mode: count stays at the bound; tc=1 every enabled cycle.
- Bounds changed mid-count: next enabled step applies the out-of-range rule if count falls outside the new range.

Test Plan:
- WIDTH=4, mode=00, min=0, max=9, up, en=1 from reset: count 0..9, then 0. tc=1 exactly on the edge 9→0, every 10 cycles.
- mode=00, decrescente=1, min=3, max=12, load 5: 5,4,3,12,11. tc=1 only on 3→12. Then en=0 for 3 cycles: count holds 11, tc=0.
- mode=10, min=2, max=5, start at 2 up: 2,3,4,5,4,3,2,3. tc=1 on 5→4 and 2→3. dir output 0→1→0 one cycle after each bounce.
- mode=11, min=0, max=3, up: 0,1,2,3,3. done=1 and single tc pulse on first enabled edge at 3; further en → no change. load 1 → done=0, count=1.
- Simultaneous/edge cases:
  - load=1 & en=1 with load_value=15, max=9 → count=9;
  - min=8, max=4 → cfg_err=1, count frozen;
  - count=12 then max changed to 9, en up → count=min.
- Assert resetar mid-count (count=7, mode=10, direction down) between clock edges: outputs go to RESET_VALUE, dir=0, tc=0, done=0 immediately, before the next edge. Counting resumes upward after release.
